// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one 20-bit byte-wide memory port between the 8088
// core and a single DMA requester (video scanout or disk DMA).
//
// Every access takes WAIT_STATES+1 cycles. The last cycle of an access raises
// the owner's completion strobe (cpu_locked or dma_ack) and arbitrates the
// next owner. The DMA wins every arbitration until MAX_BURST consecutive DMA
// accesses have run. After that, one CPU access is forced.
//
// Ports:
//   clock, reset                system clock, async active-high reset
//   pll_locked                  run enable; 0 freezes arbiter and core
//   cpu_address/out/we          core request, held until cpu_locked
//   cpu_in, cpu_locked          read data and completion strobe to core
//   dma_req/address/wdata/we    DMA request, held until dma_ack
//   dma_ack, dma_rdata          completion pulse and read data to DMA
//   dma_grant                   port currently owned by DMA
//   mem_address/wdata/we        muxed memory port
//   mem_rdata                   same-cycle memory read data
module mem_bus_arbiter #(
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned MAX_BURST   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pll_locked,
  input  logic [19:0] cpu_address,
  input  logic [7:0]  cpu_out,
  input  logic        cpu_we,
  output logic [7:0]  cpu_in,
  output logic        cpu_locked,
  input  logic        dma_req,
  input  logic [19:0] dma_address,
  input  logic [7:0]  dma_wdata,
  input  logic        dma_we,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  output logic        dma_grant,
  output logic [19:0] mem_address,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata
);

  localparam logic [3:0] WAIT_LAST  = 4'(WAIT_STATES);
  localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

  typedef enum logic {
    S_CPU = 1'b0,
    S_DMA = 1'b1
  } state_t;

  state_t     state;
  logic [3:0] wait_cnt;
  logic [7:0] burst_cnt;
  logic       last;
  logic       dma_owner;

  assign last      = (wait_cnt == WAIT_LAST);
  assign dma_owner = (state == S_DMA);

  // Access sequencing and arbitration. Nothing advances while pll_locked is low.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_CPU;
      wait_cnt  <= 4'd0;
      burst_cnt <= 8'd0;
    end else if (pll_locked) begin
      if (!last) begin
        wait_cnt <= wait_cnt + 4'd1;
      end else begin
        wait_cnt <= 4'd0;
        if (dma_req && (burst_cnt < BURST_LIMIT)) begin
          state     <= S_DMA;
          burst_cnt <= burst_cnt + 8'd1;
        end else begin
          state     <= S_CPU;
          burst_cnt <= 8'd0;
        end
      end
    end
  end

  // Port mux. Only the owner's write enable reaches memory.
  // Reset also masks the strobes combinationally, so an access that reset
  // aborts cannot complete in that cycle.
  assign mem_address = dma_owner ? dma_address : cpu_address;
  assign mem_wdata   = dma_owner ? dma_wdata   : cpu_out;
  assign mem_we      = !reset && pll_locked && (dma_owner ? dma_we : cpu_we);

  assign cpu_in      = mem_rdata;
  assign dma_rdata   = mem_rdata;

  assign cpu_locked  = !reset && pll_locked && !dma_owner && last;
  assign dma_ack     = !reset && pll_locked && dma_owner && last;
  assign dma_grant   = !reset && dma_owner;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed bench for mem_bus_arbiter.
// Three instances share one set of stimulus and differ only in parameters:
//   a: WAIT_STATES=0, b: WAIT_STATES=2, c: WAIT_STATES=3. All use MAX_BURST=4.
// Each instance sees a memory model that returns a fixed function of its
// address.
module tb_mem_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        pll_locked;
  logic [19:0] cpu_address;
  logic [7:0]  cpu_out;
  logic        cpu_we;
  logic        dma_req;
  logic [19:0] dma_address;
  logic [7:0]  dma_wdata;
  logic        dma_we;

  logic [7:0]  a_cpu_in, b_cpu_in, c_cpu_in;
  logic        a_cpu_locked, b_cpu_locked, c_cpu_locked;
  logic        a_dma_ack, b_dma_ack, c_dma_ack;
  logic [7:0]  a_dma_rdata, b_dma_rdata, c_dma_rdata;
  logic        a_dma_grant, b_dma_grant, c_dma_grant;
  logic [19:0] a_mem_address, b_mem_address, c_mem_address;
  logic [7:0]  a_mem_wdata, b_mem_wdata, c_mem_wdata;
  logic        a_mem_we, b_mem_we, c_mem_we;
  logic [7:0]  a_mem_rdata, b_mem_rdata, c_mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  function automatic logic [7:0] mem_model(input logic [19:0] addr);
    if (addr == 20'hFFFF0) return 8'hEA;
    return addr[7:0] ^ addr[15:8] ^ 8'h3C;
  endfunction

  assign a_mem_rdata = mem_model(a_mem_address);
  assign b_mem_rdata = mem_model(b_mem_address);
  assign c_mem_rdata = mem_model(c_mem_address);

  mem_bus_arbiter #(.WAIT_STATES(0), .MAX_BURST(4)) u_a (
    .clock(clock), .reset(reset), .pll_locked(pll_locked),
    .cpu_address(cpu_address), .cpu_out(cpu_out), .cpu_we(cpu_we),
    .cpu_in(a_cpu_in), .cpu_locked(a_cpu_locked),
    .dma_req(dma_req), .dma_address(dma_address), .dma_wdata(dma_wdata),
    .dma_we(dma_we), .dma_ack(a_dma_ack), .dma_rdata(a_dma_rdata),
    .dma_grant(a_dma_grant), .mem_address(a_mem_address),
    .mem_wdata(a_mem_wdata), .mem_we(a_mem_we), .mem_rdata(a_mem_rdata)
  );

  mem_bus_arbiter #(.WAIT_STATES(2), .MAX_BURST(4)) u_b (
    .clock(clock), .reset(reset), .pll_locked(pll_locked),
    .cpu_address(cpu_address), .cpu_out(cpu_out), .cpu_we(cpu_we),
    .cpu_in(b_cpu_in), .cpu_locked(b_cpu_locked),
    .dma_req(dma_req), .dma_address(dma_address), .dma_wdata(dma_wdata),
    .dma_we(dma_we), .dma_ack(b_dma_ack), .dma_rdata(b_dma_rdata),
    .dma_grant(b_dma_grant), .mem_address(b_mem_address),
    .mem_wdata(b_mem_wdata), .mem_we(b_mem_we), .mem_rdata(b_mem_rdata)
  );

  mem_bus_arbiter #(.WAIT_STATES(3), .MAX_BURST(4)) u_c (
    .clock(clock), .reset(reset), .pll_locked(pll_locked),
    .cpu_address(cpu_address), .cpu_out(cpu_out), .cpu_we(cpu_we),
    .cpu_in(c_cpu_in), .cpu_locked(c_cpu_locked),
    .dma_req(dma_req), .dma_address(dma_address), .dma_wdata(dma_wdata),
    .dma_we(dma_we), .dma_ack(c_dma_ack), .dma_rdata(c_dma_rdata),
    .dma_grant(c_dma_grant), .mem_address(c_mem_address),
    .mem_wdata(c_mem_wdata), .mem_we(c_mem_we), .mem_rdata(c_mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Step to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reset pulse. It returns with reset low, so the next edge is the first
  // active one and wait_cnt is 0.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [19:0] exp_addr;
    logic        exp_ack;
    int          idx;

    reset       = 1'b1;
    pll_locked  = 1'b1;
    cpu_address = 20'h12345;
    cpu_out     = 8'h00;
    cpu_we      = 1'b1;
    dma_req     = 1'b0;
    dma_address = 20'h00000;
    dma_wdata   = 8'h00;
    dma_we      = 1'b0;

    // Reset state. cpu_we is high so that a clear mem_we means something.
    tick();
    #1;
    check("rst_cpu_locked", 32'(a_cpu_locked), 32'd0);
    check("rst_dma_ack",    32'(a_dma_ack),    32'd0);
    check("rst_dma_grant",  32'(a_dma_grant),  32'd0);
    check("rst_mem_we",     32'(a_mem_we),     32'd0);
    check("rst_mem_addr",   32'(a_mem_address), 32'h12345);

    // Core read at FFFF0, no wait states, no DMA.
    cpu_we = 1'b0;
    cpu_address = 20'hFFFF0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      #1;
      check("rd_cpu_locked", 32'(a_cpu_locked), 32'd1);
      check("rd_mem_addr",   32'(a_mem_address), 32'hFFFF0);
      check("rd_cpu_in",     32'(a_cpu_in),     32'hEA);
      tick();
    end
    // pll_locked low stops the core strobe.
    pll_locked = 1'b0;
    cpu_we = 1'b1;
    #1;
    check("pll_cpu_locked", 32'(a_cpu_locked), 32'd0);
    check("pll_mem_we",     32'(a_mem_we),     32'd0);
    pll_locked = 1'b1;
    cpu_we = 1'b0;

    // Core write 55 to 00167, two wait states.
    do_reset();
    cpu_address = 20'h00167;
    cpu_out     = 8'h55;
    cpu_we      = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("ws2_mem_we",     32'(b_mem_we),      32'd1);
      check("ws2_cpu_locked", 32'(b_cpu_locked),  (k == 2) ? 32'd1 : 32'd0);
      check("ws2_mem_wdata",  32'(b_mem_wdata),   32'h55);
      check("ws2_mem_addr",   32'(b_mem_address), 32'h00167);
      tick();
    end
    cpu_we = 1'b0;

    // DMA burst reads with req held: one CPU cycle, then 4 DMA, 1 CPU, and so on.
    cpu_address = 20'h00400;
    do_reset();
    dma_req = 1'b1;
    dma_we  = 1'b0;
    idx = 0;
    for (int k = 0; k < 13; k++) begin
      exp_addr    = 20'hB8000 + 20'(idx);
      dma_address = exp_addr;
      exp_ack     = ((k % 5) != 0);
      #1;
      check("burst_ack",        32'(a_dma_ack),    32'(exp_ack));
      check("burst_cpu_locked", 32'(a_cpu_locked), 32'(!exp_ack));
      check("burst_grant",      32'(a_dma_grant),  32'(exp_ack));
      if (exp_ack) begin
        check("burst_rdata", 32'(a_dma_rdata), 32'(mem_model(exp_addr)));
        idx++;
      end
      tick();
    end
    dma_req = 1'b0;
    check("burst_count", 32'(idx), 32'd10);

    // Single DMA write of A5 between two core pushes.
    do_reset();
    cpu_address = 20'h0FFFE;
    cpu_out     = 8'h12;
    cpu_we      = 1'b1;
    dma_req     = 1'b1;
    dma_we      = 1'b1;
    dma_address = 20'hB8000;
    dma_wdata   = 8'hA5;
    #1;
    check("push1_locked", 32'(a_cpu_locked),  32'd1);
    check("push1_addr",   32'(a_mem_address), 32'h0FFFE);
    check("push1_wdata",  32'(a_mem_wdata),   32'h12);
    tick();
    cpu_address = 20'h0FFFD;
    cpu_out     = 8'h34;
    dma_req     = 1'b0;
    #1;
    check("dmaw_grant",  32'(a_dma_grant),   32'd1);
    check("dmaw_ack",    32'(a_dma_ack),     32'd1);
    check("dmaw_we",     32'(a_mem_we),      32'd1);
    check("dmaw_addr",   32'(a_mem_address), 32'hB8000);
    check("dmaw_wdata",  32'(a_mem_wdata),   32'hA5);
    check("dmaw_locked", 32'(a_cpu_locked),  32'd0);
    tick();
    #1;
    check("push2_grant",  32'(a_dma_grant),   32'd0);
    check("push2_locked", 32'(a_cpu_locked),  32'd1);
    check("push2_we",     32'(a_mem_we),      32'd1);
    check("push2_addr",   32'(a_mem_address), 32'h0FFFD);
    check("push2_wdata",  32'(a_mem_wdata),   32'h34);
    cpu_we = 1'b0;
    dma_we = 1'b0;

    // pll_locked low for 5 cycles during a DMA wait, three wait states.
    do_reset();
    dma_req     = 1'b1;
    dma_address = 20'hB8100;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("ws3_cpu_locked", 32'(c_cpu_locked), (k == 3) ? 32'd1 : 32'd0);
      tick();
    end
    #1;
    check("ws3_grant", 32'(c_dma_grant), 32'd1);
    check("ws3_ack0",  32'(c_dma_ack),   32'd0);
    tick();
    pll_locked = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("frz_ack",    32'(c_dma_ack),    32'd0);
      check("frz_locked", 32'(c_cpu_locked), 32'd0);
      check("frz_grant",  32'(c_dma_grant),  32'd1);
      tick();
    end
    pll_locked = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("thaw_ack", 32'(c_dma_ack), (k == 2) ? 32'd1 : 32'd0);
      if (k == 2) begin
        check("thaw_rdata", 32'(c_dma_rdata), 32'(mem_model(20'hB8100)));
        dma_req = 1'b0;
      end
      tick();
    end

    // Reset during a DMA wait cycle aborts the access.
    do_reset();
    dma_req = 1'b1;
    dma_we  = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    #1;
    check("abort_pre_grant", 32'(c_dma_grant), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_grant", 32'(c_dma_grant), 32'd0);
    check("abort_we",    32'(c_mem_we),    32'd0);
    check("abort_ack",   32'(c_dma_ack),   32'd0);
    dma_req = 1'b0;
    dma_we  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("post_grant",  32'(c_dma_grant),  32'd0);
      check("post_ack",    32'(c_dma_ack),    32'd0);
      check("post_locked", 32'(c_cpu_locked), (k == 3) ? 32'd1 : 32'd0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
